// File: rtl/psum_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Purpose  : Per-address partial-sum accumulation with RMW forwarding, then
//            in-order int8 requantized drain over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
    parameter int ADDR_PSUM = 12,
    parameter int PSUM_BW   = 32,
    parameter int OUT_BW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_PSUM:0]    num_entries,
    input  logic [4:0]            shift,
    input  logic                  psum_valid,
    input  logic [PSUM_BW-1:0]    psum_data,
    input  logic [ADDR_PSUM-1:0]  psum_addr,
    input  logic                  psum_last,
    output logic                  psum_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BW-1:0]     out_data,
    output logic [ADDR_PSUM-1:0]  out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err
);

    localparam int DEPTH = 1 << ADDR_PSUM;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ACCUM = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic signed [PSUM_BW:0] EXT_ONE = (PSUM_BW+1)'(1);
    localparam logic signed [PSUM_BW:0] QMAX    = (PSUM_BW+1)'((1 << (OUT_BW-1)) - 1);
    localparam logic signed [PSUM_BW:0] QMIN    = ~QMAX;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ADDR_PSUM:0]    r_n;
    logic [4:0]            r_shift;
    logic [ADDR_PSUM:0]    r_ptr;
    logic                  r_flush_cnt;

    logic                  w_psum_ready;
    logic                  w_busy;
    logic                  w_clearing;
    logic                  w_draining;

    logic [PSUM_BW-1:0]    r_mem [DEPTH];
    logic [PSUM_BW-1:0]    r_rd_data;
    logic                  w_mem_we;
    logic [ADDR_PSUM-1:0]  w_mem_waddr;
    logic [PSUM_BW-1:0]    w_mem_wdata;
    logic                  w_mem_re;
    logic [ADDR_PSUM-1:0]  w_mem_raddr;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  r_s1_valid;
    logic [ADDR_PSUM-1:0]  r_s1_addr;
    logic [PSUM_BW-1:0]    r_s1_data;
    logic                  r_s2_valid;
    logic [ADDR_PSUM-1:0]  r_s2_addr;
    logic [PSUM_BW-1:0]    r_s2_sum;
    logic                  w_fwd;
    logic [PSUM_BW-1:0]    w_operand;
    logic [PSUM_BW-1:0]    w_sum;

    logic                  r_dr_valid;
    logic [ADDR_PSUM-1:0]  r_dr_addr;
    logic                  w_out_load;
    logic                  w_issue;
    logic                  w_drain_end;
    logic                  r_out_valid;
    logic [OUT_BW-1:0]     r_out_data;
    logic [ADDR_PSUM-1:0]  r_out_addr;
    logic                  r_done;
    logic                  r_addr_err;

    logic signed [PSUM_BW:0] w_ext;
    logic signed [PSUM_BW:0] w_rnd;
    logic signed [PSUM_BW:0] w_t;
    logic [OUT_BW-1:0]       w_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = (num_entries == '0) ? ST_ACCUM : ST_CLEAR;
            ST_CLEAR: if (r_ptr + 1'b1 == r_n) w_next = ST_ACCUM;
            ST_ACCUM: if (psum_last) w_next = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_end) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_psum_ready = (r_state == ST_ACCUM);
        w_busy       = (r_state != ST_IDLE);
        w_clearing   = (r_state == ST_CLEAR);
        w_draining   = (r_state == ST_DRAIN);
    end

    assign w_accept   = psum_valid && w_psum_ready;
    assign w_in_range = ({1'b0, psum_addr} < r_n);

    // Drain pipeline: issue read -> read-data stage -> output register.
    assign w_out_load  = !r_out_valid || out_ready;
    assign w_issue     = w_draining && (r_ptr < r_n) && (!r_dr_valid || w_out_load);
    assign w_drain_end = (r_ptr == r_n) && !r_dr_valid && (!r_out_valid || out_ready);

    // The previous beat's write lands on the same edge this beat's read is
    // issued, so its sum must come from stage 2 instead of the memory.
    assign w_fwd     = r_s2_valid && (r_s2_addr == r_s1_addr);
    assign w_operand = w_fwd ? r_s2_sum : r_rd_data;
    assign w_sum     = w_operand + r_s1_data;

    assign w_mem_we    = w_clearing || r_s1_valid;
    assign w_mem_waddr = w_clearing ? r_ptr[ADDR_PSUM-1:0] : r_s1_addr;
    assign w_mem_wdata = w_clearing ? '0 : w_sum;
    assign w_mem_re    = w_accept || w_issue;
    assign w_mem_raddr = w_draining ? r_ptr[ADDR_PSUM-1:0] : psum_addr;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
        if (w_mem_re) r_rd_data <= r_mem[w_mem_raddr];
    end

    // Rounding add is done one bit wider so it cannot wrap.
    always_comb begin
        w_ext = {r_rd_data[PSUM_BW-1], r_rd_data};
        w_rnd = '0;
        w_t   = w_ext;
        if (r_shift != 5'd0) begin
            w_rnd = EXT_ONE << (r_shift - 5'd1);
            w_t   = (w_ext + w_rnd) >>> r_shift;
        end
        if (w_t > QMAX)      w_q = QMAX[OUT_BW-1:0];
        else if (w_t < QMIN) w_q = QMIN[OUT_BW-1:0];
        else                 w_q = w_t[OUT_BW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n         <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_flush_cnt <= 1'b0;
            r_addr_err  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_n     <= num_entries;
                r_shift <= shift;
            end
            case (r_state)
                ST_CLEAR: r_ptr <= r_ptr + 1'b1;
                ST_DRAIN: if (w_issue) r_ptr <= r_ptr + 1'b1;
                default:  r_ptr <= '0;
            endcase
            r_flush_cnt <= (r_state == ST_FLUSH) ? ~r_flush_cnt : 1'b0;
            if (r_state == ST_IDLE && start)
                r_addr_err <= 1'b0;
            else if (w_accept && !w_in_range)
                r_addr_err <= 1'b1;
            r_done <= w_draining && w_drain_end;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_sum   <= '0;
        end else begin
            r_s1_valid <= w_accept && w_in_range;
            r_s1_addr  <= psum_addr;
            r_s1_data  <= psum_data;
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_sum   <= w_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dr_valid  <= 1'b0;
            r_dr_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            if (w_issue) begin
                r_dr_valid <= 1'b1;
                r_dr_addr  <= r_ptr[ADDR_PSUM-1:0];
            end else if (r_dr_valid && w_out_load) begin
                r_dr_valid <= 1'b0;
            end
            if (w_out_load) begin
                r_out_valid <= r_dr_valid;
                if (r_dr_valid) begin
                    r_out_data <= w_q;
                    r_out_addr <= r_dr_addr;
                end
            end
        end
    end

    assign psum_ready = w_psum_ready;
    assign busy       = w_busy;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_addr   = r_out_addr;
    assign done       = r_done;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Purpose  : Table-driven tile vectors plus backpressure and mid-tile reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;
    localparam int A = 12;
    localparam int P = 32;
    localparam int O = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [A:0]   num_entries;
    logic [4:0]   shift;
    logic         psum_valid;
    logic [P-1:0] psum_data;
    logic [A-1:0] psum_addr;
    logic         psum_last;
    logic         psum_ready;
    logic         out_valid;
    logic         out_ready;
    logic [O-1:0] out_data;
    logic [A-1:0] out_addr;
    logic         busy;
    logic         done;
    logic         addr_err;

    psum_accumulator #(.ADDR_PSUM(A), .PSUM_BW(P), .OUT_BW(O)) dut (
        .clk(clk), .reset(reset), .start(start), .num_entries(num_entries),
        .shift(shift), .psum_valid(psum_valid), .psum_data(psum_data),
        .psum_addr(psum_addr), .psum_last(psum_last), .psum_ready(psum_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    n;
        int                    sh;
        int                    nb;
        int                    ne;
        logic [15:0][A-1:0]    ba;
        logic [15:0][P-1:0]    bd;
        logic [7:0][O-1:0]     ex;
        logic                  err;
    } vec_t;

    vec_t vecs [16];
    int   nv = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void new_vec(input int n, input int sh, input logic err);
        vecs[nv].n   = n;
        vecs[nv].sh  = sh;
        vecs[nv].nb  = 0;
        vecs[nv].ne  = 0;
        vecs[nv].ba  = '0;
        vecs[nv].bd  = '0;
        vecs[nv].ex  = '0;
        vecs[nv].err = err;
        nv++;
    endfunction

    function automatic void beat(input int a, input int d);
        vecs[nv-1].ba[vecs[nv-1].nb] = A'(a);
        vecs[nv-1].bd[vecs[nv-1].nb] = P'(d);
        vecs[nv-1].nb++;
    endfunction

    function automatic void ex(input int v);
        vecs[nv-1].ex[vecs[nv-1].ne] = O'(v);
        vecs[nv-1].ne++;
    endfunction

    task automatic outs_zero(input string tag);
        chk({tag, "_psum_ready"}, psum_ready, 0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_out_addr"},   out_addr,   0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_addr_err"},   addr_err,   0);
    endtask

    // mode 0: out_ready always high; mode 1: 1,0,0,1 pattern and start held high
    task automatic run_tile(input int k, input int mode);
        vec_t v;
        int   cnt;
        int   idx;
        bit   got_done;
        bit   rdy;
        v = vecs[k];
        @(negedge clk);
        start       = 1'b1;
        num_entries = (A+1)'(v.n);
        shift       = 5'(v.sh);
        @(negedge clk);
        if (mode == 0) start = 1'b0;
        else           num_entries = '0;
        chk($sformatf("t%0d_busy_rise", k), busy, 1);
        cnt = 0;
        while (!psum_ready && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk($sformatf("t%0d_clear_len", k), cnt, v.n);
        for (int j = 0; j < v.nb; j++) begin
            chk($sformatf("t%0d_ready_b%0d", k, j), psum_ready, 1);
            psum_valid = 1'b1;
            psum_addr  = v.ba[j];
            psum_data  = v.bd[j];
            psum_last  = (j == v.nb - 1);
            @(negedge clk);
        end
        if (v.nb == 0) begin
            psum_last = 1'b1;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        start      = 1'b0;
        idx        = 0;
        got_done   = 1'b0;
        for (int it = 1; it <= 5000 && !got_done; it++) begin
            rdy = (mode == 0) ? 1'b1 : ((it % 4) == 1 || (it % 4) == 0);
            out_ready = rdy;
            if (done) begin
                got_done = 1'b1;
                chk($sformatf("t%0d_beat_count", k), idx, v.n);
                chk($sformatf("t%0d_idle_at_done", k), busy, 0);
                chk($sformatf("t%0d_addr_err", k), addr_err, v.err);
                if (mode == 0 && v.n > 0)
                    chk($sformatf("t%0d_latency", k), it, v.n + 5);
            end else begin
                if (out_valid) begin
                    if (idx >= v.n) begin
                        chk($sformatf("t%0d_extra_beat", k), out_valid, 0);
                    end else begin
                        chk($sformatf("t%0d_addr%0d", k, idx), out_addr, idx);
                        chk($sformatf("t%0d_data%0d", k, idx), out_data, v.ex[idx]);
                        if (rdy) idx++;
                    end
                end
                @(negedge clk);
            end
        end
        chk($sformatf("t%0d_done_seen", k), got_done, 1);
        @(negedge clk);
        chk($sformatf("t%0d_done_pulse", k), done, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_idx;
        int rs_idx;
        int cnt;
        reset = 1'b1; start = 1'b0; num_entries = '0; shift = '0;
        psum_valid = 1'b0; psum_data = '0; psum_addr = '0; psum_last = 1'b0;
        out_ready = 1'b0;

        new_vec(4, 0, 0);  beat(0, 5); beat(1, -3); beat(0, 7);
                           ex(12); ex(-3); ex(0); ex(0);
        new_vec(1, 0, 0);  for (int i = 0; i < 10; i++) beat(0, 1);
                           ex(10);
        new_vec(3, 4, 0);  beat(0, 24); beat(1, -24); beat(2, 5000);
                           ex(2); ex(-1); ex(127);
        new_vec(1, 4, 0);  beat(0, -5000); ex(-128);
        new_vec(2, 0, 1);  beat(0, 3); beat(3, 100); beat(1, 4);
                           ex(3); ex(4);
        new_vec(1, 0, 0);  beat(0, 32'h7FFF_FFFF); beat(0, 1); ex(-128);
        new_vec(1, 31, 0); beat(0, 32'h4000_0000); ex(1);
        new_vec(2, 1, 0);  beat(0, -3); beat(1, 3); ex(-1); ex(2);
        new_vec(2, 0, 0);  beat(0, 1); beat(1, 2); beat(0, 4); beat(1, 8); beat(0, 16);
                           ex(21); ex(10);
        new_vec(0, 0, 0);
        bp_idx = nv;
        new_vec(8, 0, 0);  for (int i = 0; i < 8; i++) begin beat(i, 10*i - 30); ex(10*i - 30); end
        rs_idx = nv;
        new_vec(2, 0, 0);  beat(0, 6); beat(1, -2); ex(6); ex(-2);

        repeat (3) @(negedge clk);
        outs_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        outs_zero("idle");

        for (int k = 0; k < nv; k++) run_tile(k, 0);
        run_tile(bp_idx, 1);

        // Abort a tile mid-ACCUM, then check a fresh tile sees no carryover.
        @(negedge clk);
        start = 1'b1; num_entries = 13'd4; shift = 5'd0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!psum_ready && cnt < 5000) begin cnt++; @(negedge clk); end
        psum_valid = 1'b1; psum_addr = 12'd0; psum_data = 32'd100;
        @(negedge clk);
        psum_addr = 12'd1; psum_data = 32'd200;
        @(negedge clk);
        psum_addr = 12'd9; psum_data = 32'd1;
        @(negedge clk);
        psum_valid = 1'b0;
        chk("abort_addr_err_set", addr_err, 1);
        chk("abort_in_accum", psum_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        outs_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        run_tile(rs_idx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
